alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
Shares one 8-bit ALU (opa/opb 8b, cmd 4b, mode, cin, inp_valid 2b, res 16b, flags err/oflow/cout/g/l/e) between NUM_REQ requesters.
- Round-robin grant; issues one operation at a time as a single-cycle ce pulse.
- Waits a fixed command-dependent latency, captures result and flags, returns them to the granted requester over a valid/ready response channel.
- Sits between the requester bus and the ALU input/output pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ALU_LAT, 1, cycles from ce pulse to valid res for non-multiply commands (1..7)
MUL_LAT, 2, cycles from ce pulse to valid res for mode=1, cmd=9 or 10 (1..7)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_mode  in  NUM_REQ  per-requester mode
req_cin  in  NUM_REQ  per-requester carry-in
req_cmd  in  4*NUM_REQ  packed cmd, requester i at [4i+3:4i]
req_inp_valid  in  2*NUM_REQ  packed inp_valid
req_opa  in  8*NUM_REQ  packed opa
req_opb  in  8*NUM_REQ  packed opb
alu_ce, alu_mode, alu_cin  out  1  ALU controls
alu_cmd  out  4  ALU command
alu_inp_valid  out  2  ALU operand valid
alu_opa, alu_opb  out  8  ALU operands
alu_res  in  16  ALU result
alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1  ALU flags
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NUM_REQ)  requester index of response
rsp_res  out  16  captured result
rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e  out  1  captured flags

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM=IDLE; last_grant=NUM_REQ-1 so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant first set bit searching from last_grant+1 with wrap.
  - Pulse req_ready[g]=1 that same cycle; latch the request fields and g; update last_grant=g; go ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - alu_ce=1; alu_* driven from the latch.
  - Load counter = LAT-1, where LAT=MUL_LAT if latched mode=1 and cmd is 9 or 10, else ALU_LAT. Go WAIT.
  - If latched inp_valid=2'b00: no ce pulse. Go RESP with rsp_err=1, rsp_res=0, other flags 0.
- WAIT:
  - alu_ce=0; alu operand outputs hold last values.
  - Decrement counter. At counter=0, capture alu_res and flags into rsp_* registers at the posedge. Go RESP.
  - Capture occurs LAT cycles after the ISSUE cycle.
- RESP:
  - rsp_valid=1; rsp_* stable until rsp_valid&&rsp_ready; then rsp_valid=0 next cycle, go IDLE.
- Timing:
  - req_ready is never asserted outside IDLE; requesters hold req_valid and fields until accepted.
  - Minimum occupancy per operation: IDLE(1)+ISSUE(1)+LAT+1 cycles before the next grant.
  - Requests deasserted before grant are simply not granted; no latching happens.
- Reset mid-operation: FSM returns to IDLE, pending response discarded, alu_ce forced 0 immediately.

Optional Feature:
ALU_ARB_STATS_EN
- Defined: adds output grant_cnt (8*NUM_REQ, packed per requester). Counter i increments on each req_ready[i] pulse, saturates at 255, clears on reset.
- Undefined: port and counters absent; behaviour otherwise identical.

Test Plan:
- Single requester 0: mode=1, cmd=0 (ADD), opa=8'hF0, opb=8'h20, inp_valid=3 -> alu_ce one cycle; rsp_id=0, rsp_res=16'h0110, rsp_cout=1 after ALU_LAT cycles.
- All 4 req_valid held high -> grant order 0,1,2,3,0; each req_ready is a single-cycle pulse.
- Multiply: mode=1, cmd=9, opa=3, opb=4 -> capture occurs MUL_LAT (2) cycles after ce; rsp_res matches ALU output at that cycle.
- inp_valid=0 from requester 2 -> no alu_ce; rsp_valid with rsp_err=1, rsp_res=0, rsp_id=2.
- rsp_ready held 0 for 5 cycles -> rsp_* stable; req_ready stays 0; new grant only after the accept cycle.
- rst asserted during WAIT -> all outputs 0 asynchronously; after release requester 0 wins first.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// Bus bundle for alu_req_arbiter: requester side, ALU pin side and response channel.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_mode;
  logic [NUM_REQ-1:0]   req_cin;
  logic [4*NUM_REQ-1:0] req_cmd;
  logic [2*NUM_REQ-1:0] req_inp_valid;
  logic [8*NUM_REQ-1:0] req_opa;
  logic [8*NUM_REQ-1:0] req_opb;

  logic                 alu_ce;
  logic                 alu_mode;
  logic                 alu_cin;
  logic [3:0]           alu_cmd;
  logic [1:0]           alu_inp_valid;
  logic [7:0]           alu_opa;
  logic [7:0]           alu_opb;
  logic [15:0]          alu_res;
  logic                 alu_err;
  logic                 alu_oflow;
  logic                 alu_cout;
  logic                 alu_g;
  logic                 alu_l;
  logic                 alu_e;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_res;
  logic                 rsp_err;
  logic                 rsp_oflow;
  logic                 rsp_cout;
  logic                 rsp_g;
  logic                 rsp_l;
  logic                 rsp_e;

  modport slave (
    input  req_valid, req_mode, req_cin, req_cmd, req_inp_valid, req_opa, req_opb,
    output req_ready,
    output alu_ce, alu_mode, alu_cin, alu_cmd, alu_inp_valid, alu_opa, alu_opb,
    input  alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
    output rsp_valid, rsp_id, rsp_res, rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_mode, req_cin, req_cmd, req_inp_valid, req_opa, req_opb,
    input  req_ready,
    input  alu_ce, alu_mode, alu_cin, alu_cmd, alu_inp_valid, alu_opa, alu_opb,
    output alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
    input  rsp_valid, rsp_id, rsp_res, rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e,
    output rsp_ready
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between NUM_REQ requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef ALU_ARB_STATS_EN
  output logic [8*NUM_REQ-1:0] grant_cnt,
  alu_req_arbiter_if.slave     bus
`else
  alu_req_arbiter_if.slave     bus
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [2:0] ALU_CNT = 3'(ALU_LAT - 1);
  localparam logic [2:0] MUL_CNT = 3'(MUL_LAT - 1);

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            mode_q, mode_d;
  logic            cin_q, cin_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [1:0]      iv_q, iv_d;
  logic [7:0]      opa_q, opa_d;
  logic [7:0]      opb_q, opb_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     res_q, res_d;
  logic [5:0]      flags_q, flags_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               sel_mode;
  logic               sel_cin;
  logic [3:0]         sel_cmd;
  logic [1:0]         sel_iv;
  logic [7:0]         sel_opa;
  logic [7:0]         sel_opb;
  logic               is_mul;

  // Second pass overrides the first, so the lowest index above last_q wins, else wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j] && (ID_W'(j) <= last_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j] && (ID_W'(j) > last_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  assign grant_oh = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_mode = 1'b0;
    sel_cin  = 1'b0;
    sel_cmd  = '0;
    sel_iv   = '0;
    sel_opa  = '0;
    sel_opb  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_idx == ID_W'(j)) begin
        sel_mode = bus.req_mode[j];
        sel_cin  = bus.req_cin[j];
        sel_cmd  = bus.req_cmd[4*j +: 4];
        sel_iv   = bus.req_inp_valid[2*j +: 2];
        sel_opa  = bus.req_opa[8*j +: 8];
        sel_opb  = bus.req_opb[8*j +: 8];
      end
    end
  end

  assign is_mul = mode_q && ((cmd_q == 4'd9) || (cmd_q == 4'd10));

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    mode_d      = mode_q;
    cin_d       = cin_q;
    cmd_d       = cmd_q;
    iv_d        = iv_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d = ST_ISSUE;
          last_d  = grant_idx;
          id_d    = grant_idx;
          mode_d  = sel_mode;
          cin_d   = sel_cin;
          cmd_d   = sel_cmd;
          iv_d    = sel_iv;
          opa_d   = sel_opa;
          opb_d   = sel_opb;
        end
      end
      ST_ISSUE: begin
        // No operands valid: skip the ALU and answer with an error response.
        if (iv_q == 2'b00) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          res_d       = '0;
          flags_d     = 6'b100000;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = is_mul ? MUL_CNT : ALU_CNT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          res_d       = bus.alu_res;
          flags_d     = {bus.alu_err, bus.alu_oflow, bus.alu_cout,
                         bus.alu_g, bus.alu_l, bus.alu_e};
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      cmd_q       <= '0;
      iv_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      mode_q      <= mode_d;
      cin_q       <= cin_d;
      cmd_q       <= cmd_d;
      iv_q        <= iv_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

  // Gated by rst so the accept pulse stays low while reset is held.
  assign bus.req_ready     = (rst && (state_q == ST_IDLE)) ? grant_oh : '0;

  assign bus.alu_ce        = (state_q == ST_ISSUE) && (iv_q != 2'b00);
  assign bus.alu_mode      = mode_q;
  assign bus.alu_cin       = cin_q;
  assign bus.alu_cmd       = cmd_q;
  assign bus.alu_inp_valid = iv_q;
  assign bus.alu_opa       = opa_q;
  assign bus.alu_opb       = opb_q;

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = id_q;
  assign bus.rsp_res       = res_q;
  assign bus.rsp_err       = flags_q[5];
  assign bus.rsp_oflow     = flags_q[4];
  assign bus.rsp_cout      = flags_q[3];
  assign bus.rsp_g         = flags_q[2];
  assign bus.rsp_l         = flags_q[1];
  assign bus.rsp_e         = flags_q[0];

`ifdef ALU_ARB_STATS_EN
  logic [7:0] gcnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i] && (gcnt_q[i] != 8'hFF)) gcnt_q[i] <= gcnt_q[i] + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_grant_cnt
    assign grant_cnt[8*i +: 8] = gcnt_q[i];
  end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter (NUM_REQ=4, ALU_LAT=1, MUL_LAT=2).
// The ALU model only presents a valid result exactly LAT cycles after ce; otherwise 16'hDEAD with err=1.
module tb_alu_req_arbiter;

  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [8*NUM_REQ-1:0] grantCnt;
`endif

  alu_req_arbiter #(.NUM_REQ(NUM_REQ), .ALU_LAT(1), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt (grantCnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural ALU: cmd 0 = add, cmd 9 = multiply, anything else = concatenation.
  logic [15:0] pipeRes = '0;
  logic [5:0]  pipeFlags = '0;
  logic [2:0]  pipeAge = 3'd7;
  logic [2:0]  pipeLat = 3'd1;
  logic [8:0]  sum9;
  logic        aluHit;

  assign sum9 = {1'b0, bus.alu_opa} + {1'b0, bus.alu_opb};

  always @(posedge clk) begin
    if (bus.alu_ce) begin
      pipeAge <= 3'd1;
      pipeLat <= (bus.alu_mode && (bus.alu_cmd == 4'd9 || bus.alu_cmd == 4'd10)) ? 3'd2 : 3'd1;
      case (bus.alu_cmd)
        4'd0:    pipeRes <= {7'd0, sum9};
        4'd9:    pipeRes <= {8'd0, bus.alu_opa} * {8'd0, bus.alu_opb};
        default: pipeRes <= {bus.alu_opa, bus.alu_opb};
      endcase
      pipeFlags <= {1'b0, 1'b0, (bus.alu_cmd == 4'd0) && sum9[8],
                    bus.alu_opa > bus.alu_opb, bus.alu_opa < bus.alu_opb,
                    bus.alu_opa == bus.alu_opb};
    end else if (pipeAge != 3'd7) begin
      pipeAge <= pipeAge + 3'd1;
    end
  end

  assign aluHit        = (pipeAge == pipeLat);
  assign bus.alu_res   = aluHit ? pipeRes : 16'hDEAD;
  assign bus.alu_err   = aluHit ? pipeFlags[5] : 1'b1;
  assign bus.alu_oflow = aluHit ? pipeFlags[4] : 1'b0;
  assign bus.alu_cout  = aluHit ? pipeFlags[3] : 1'b0;
  assign bus.alu_g     = aluHit ? pipeFlags[2] : 1'b0;
  assign bus.alu_l     = aluHit ? pipeFlags[1] : 1'b0;
  assign bus.alu_e     = aluHit ? pipeFlags[0] : 1'b0;

  task automatic applyStimulus(input int idx, input logic valid, input logic mode,
                               input logic [3:0] cmd, input logic [1:0] iv,
                               input logic [7:0] opa, input logic [7:0] opb);
    bus.req_valid[idx]             = valid;
    bus.req_mode[idx]              = mode;
    bus.req_cin[idx]               = 1'b0;
    bus.req_cmd[4*idx +: 4]        = cmd;
    bus.req_inp_valid[2*idx +: 2]  = iv;
    bus.req_opa[8*idx +: 8]        = opa;
    bus.req_opb[8*idx +: 8]        = opb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int waitCnt;
    int lastGrantCyc;
    int expId;

    bus.req_valid     = '0;
    bus.req_mode      = '0;
    bus.req_cin       = '0;
    bus.req_cmd       = '0;
    bus.req_inp_valid = '0;
    bus.req_opa       = '0;
    bus.req_opb       = '0;
    bus.rsp_ready     = 1'b0;
    lastGrantCyc      = 0;

    // Reset held with every requester asking: nothing may be accepted.
    repeat (2) @(negedge clk);
    bus.req_valid = 4'hF;
    #1;
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("reset_alu_ce", 32'(bus.alu_ce), 32'h0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("reset_rsp_res", 32'(bus.rsp_res), 32'h0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // Single add from requester 0.
    applyStimulus(0, 1'b1, 1'b1, 4'd0, 2'd3, 8'hF0, 8'h20);
    #1;
    checkOutput("add_grant", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    checkOutput("add_ce", 32'(bus.alu_ce), 32'h1);
    checkOutput("add_alu_opa", 32'(bus.alu_opa), 32'hF0);
    checkOutput("add_alu_opb", 32'(bus.alu_opb), 32'h20);
    checkOutput("add_ready_low", 32'(bus.req_ready), 32'h0);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("add_ce_off", 32'(bus.alu_ce), 32'h0);
    checkOutput("add_wait_rsp", 32'(bus.rsp_valid), 32'h0);
    checkOutput("add_opa_hold", 32'(bus.alu_opa), 32'hF0);
    @(negedge clk);
    checkOutput("add_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("add_rsp_id", 32'(bus.rsp_id), 32'h0);
    checkOutput("add_rsp_res", 32'(bus.rsp_res), 32'h0110);
    checkOutput("add_rsp_cout", 32'(bus.rsp_cout), 32'h1);
    checkOutput("add_rsp_err", 32'(bus.rsp_err), 32'h0);
    checkOutput("add_rsp_g", 32'(bus.rsp_g), 32'h1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("add_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // All four requesting: after requester 0 the rotation is 1,2,3,0,1.
    for (int i = 0; i < NUM_REQ; i++)
      applyStimulus(i, 1'b1, 1'b1, 4'd0, 2'd3, 8'(17 * (i + 1)), 8'h01);
    #1;
    for (int n = 0; n < 5; n++) begin
      expId   = (n + 1) % NUM_REQ;
      waitCnt = 0;
      while (bus.req_ready == '0 && waitCnt < 20) begin
        @(negedge clk);
        waitCnt++;
      end
      checkOutput($sformatf("rr_grant_%0d", n), 32'(bus.req_ready), 32'(1) << expId);
      if (n > 0) checkOutput($sformatf("rr_spacing_%0d", n), 32'(cyc - lastGrantCyc), 32'd4);
      lastGrantCyc = cyc;
      @(negedge clk);
      checkOutput($sformatf("rr_pulse_%0d", n), 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput($sformatf("rr_rsp_valid_%0d", n), 32'(bus.rsp_valid), 32'h1);
      checkOutput($sformatf("rr_rsp_id_%0d", n), 32'(bus.rsp_id), 32'(expId));
      checkOutput($sformatf("rr_rsp_res_%0d", n), 32'(bus.rsp_res), 32'(17 * (expId + 1) + 1));
      if (n == 4) bus.req_valid = '0;
      @(negedge clk);
    end

    // Multiply from requester 3 with the response held off.
    bus.rsp_ready = 1'b0;
    applyStimulus(3, 1'b1, 1'b1, 4'd9, 2'd3, 8'd3, 8'd4);
    #1;
    checkOutput("mul_grant", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    checkOutput("mul_ce", 32'(bus.alu_ce), 32'h1);
    checkOutput("mul_alu_cmd", 32'(bus.alu_cmd), 32'h9);
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    checkOutput("mul_wait1_rsp", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    checkOutput("mul_wait2_rsp", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    checkOutput("mul_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("mul_rsp_res", 32'(bus.rsp_res), 32'h000C);
    checkOutput("mul_rsp_id", 32'(bus.rsp_id), 32'h3);
    checkOutput("mul_rsp_l", 32'(bus.rsp_l), 32'h1);

    // Stall: requester 2 waits (with no valid operands) while the response is unaccepted.
    applyStimulus(2, 1'b1, 1'b1, 4'd0, 2'd0, 8'h09, 8'h06);
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall_rsp_valid_%0d", k), 32'(bus.rsp_valid), 32'h1);
      checkOutput($sformatf("stall_rsp_res_%0d", k), 32'(bus.rsp_res), 32'h000C);
      checkOutput($sformatf("stall_ready_%0d", k), 32'(bus.req_ready), 32'h0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_released", 32'(bus.rsp_valid), 32'h0);
    checkOutput("noop_grant", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    checkOutput("noop_no_ce", 32'(bus.alu_ce), 32'h0);
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    checkOutput("noop_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("noop_rsp_err", 32'(bus.rsp_err), 32'h1);
    checkOutput("noop_rsp_res", 32'(bus.rsp_res), 32'h0);
    checkOutput("noop_rsp_id", 32'(bus.rsp_id), 32'h2);
    checkOutput("noop_rsp_cout", 32'(bus.rsp_cout), 32'h0);
    @(negedge clk);

    // Reset during WAIT of a multiply from requester 1.
    applyStimulus(1, 1'b1, 1'b1, 4'd10, 2'd3, 8'h05, 8'h05);
    #1;
    checkOutput("rst_case_grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    checkOutput("rst_case_ce", 32'(bus.alu_ce), 32'h1);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    checkOutput("midrst_alu_ce", 32'(bus.alu_ce), 32'h0);
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("midrst_rsp_err", 32'(bus.rsp_err), 32'h0);
    checkOutput("midrst_alu_cmd", 32'(bus.alu_cmd), 32'h0);
    checkOutput("midrst_alu_opa", 32'(bus.alu_opa), 32'h0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("postrst_grant", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    checkOutput("postrst_ce", 32'(bus.alu_ce), 32'h1);
    checkOutput("postrst_alu_opa", 32'(bus.alu_opa), 32'h11);
    bus.req_valid = '0;
    @(negedge clk);
    checkOutput("postrst_wait_rsp", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    checkOutput("postrst_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("postrst_rsp_id", 32'(bus.rsp_id), 32'h0);
    checkOutput("postrst_rsp_res", 32'(bus.rsp_res), 32'h0012);
`ifdef ALU_ARB_STATS_EN
    checkOutput("stats_grant_cnt", grantCnt, 32'h00000001);
`endif
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
